// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_bist_ctrl
// Brief    : Two-pass write/read-back march BIST for a single-port async-read
//            RAM; counts mismatches and records the first failing address.
// Revision : 1.0
// ============================================================================
module ram_bist_ctrl #(
    parameter int                 ADDR_W = 4,
    parameter int                 DATA_W = 8,
    parameter logic [DATA_W-1:0]  SEED   = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data_in,
    output logic                ram_write_en,
    input  logic [DATA_W-1:0]   ram_data_out,
    output logic                busy,
    output logic                done,
    output logic                pass_ok,
    output logic [ADDR_W+1:0]   error_count,
    output logic [ADDR_W-1:0]   first_fail_addr
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                we_q, we_d;
    logic [ADDR_W+1:0]   err_q, err_d;
    logic [ADDR_W-1:0]   ff_q, ff_d;

    // Pass 1 uses the complement so every cell sees both polarities of each bit.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic p);
        logic [DATA_W-1:0] v;
        v = SEED ^ DATA_W'(a);
        return p ? ~v : v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = we_q;
        err_d   = err_q;
        ff_d    = ff_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                we_d = 1'b0;
                if (start) begin
                    state_d = ST_WRITE;
                    pass_d  = 1'b0;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    din_d   = pat('0, 1'b0);
                    err_d   = '0;
                    ff_d    = '0;
                end
            end
            ST_WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    we_d    = 1'b0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    din_d   = pat(addr_q + 1'b1, pass_q);
                    we_d    = 1'b1;
                end
            end
            ST_READ: begin
                we_d = 1'b0;
                // Case-inequality so X/Z from the RAM is reported as a fault.
                if (ram_data_out !== pat(addr_q, pass_q)) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ff_d = addr_q;
                    end
                end
                if (addr_q == ADDR_LAST) begin
                    if (!pass_q) begin
                        state_d = ST_WRITE;
                        pass_d  = 1'b1;
                        addr_d  = '0;
                        we_d    = 1'b1;
                        din_d   = pat('0, 1'b1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_address     = addr_q;
    assign ram_data_in     = din_q;
    assign ram_write_en    = we_q;
    assign busy            = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign done            = (state_q == ST_DONE);
    assign pass_ok         = (state_q == ST_DONE) && (err_q == '0);
    assign error_count     = err_q;
    assign first_fail_addr = ff_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_bist_ctrl
// Brief    : Directed bench for ram_bist_ctrl with a behavioural async-read RAM
//            and fault injection on the RAM read path.
// Revision : 1.0
// ============================================================================
module tb_ram_bist_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic        ram_write_en;
    logic [7:0]  ram_data_out;
    logic        busy;
    logic        done;
    logic        pass_ok;
    logic [5:0]  error_count;
    logic [3:0]  first_fail_addr;

    logic [7:0]  mem [16];
    logic        stuck0;
    logic        fault9;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0] err;
        logic [3:0] ff;
        logic       ok;
    } res_t;
    res_t sb_q[$];

    ram_bist_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_write_en    (ram_write_en),
        .ram_data_out    (ram_data_out),
        .busy            (busy),
        .done            (done),
        .pass_ok         (pass_ok),
        .error_count     (error_count),
        .first_fail_addr (first_fail_addr)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_write_en) begin
            mem[ram_address] <= ram_data_in;
        end
    end

    assign ram_data_out = (mem[ram_address] | {7'b0, stuck0})
                        ^ {7'b0, (fault9 && ram_address == 4'd9)};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, 32'(ram_address), 0);
        check({tag, "_din"},  32'(ram_data_in), 0);
        check({tag, "_we"},   32'(ram_write_en), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ok"},   32'(pass_ok), 0);
        check({tag, "_err"},  32'(error_count), 0);
        check({tag, "_ff"},   32'(first_fail_addr), 0);
    endtask

    // Called at a negedge. When started=1 the run is already one cycle in.
    task automatic run_test(input string tag, input bit hold, input bit started, input bit inject9);
        int busy_cnt = 0;
        int we_cnt   = 0;
        int guard    = 0;
        logic [7:0] exp_d;
        res_t e;
        if (!started) begin
            start = 1'b1;
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
        while (busy && guard < 200) begin
            busy_cnt++;
            if (ram_write_en) begin
                exp_d = 8'hA5 ^ {4'h0, 4'(we_cnt % 16)};
                if (we_cnt >= 16) exp_d = ~exp_d;
                if (we_cnt % 4 == 0) begin
                    check({tag, "_waddr"}, 32'(ram_address), 32'(we_cnt % 16));
                    check({tag, "_wdata"}, 32'(ram_data_in), 32'(exp_d));
                end
                we_cnt++;
            end else if (inject9 && we_cnt == 32) begin
                fault9 = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        fault9 = 1'b0;
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 64);
        check({tag, "_we_cycles"},   32'(we_cnt), 32);
        check({tag, "_done"},        32'(done), 1);
        check({tag, "_we_idle"},     32'(ram_write_en), 0);
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_err"},     32'(error_count), 32'(e.err));
            check({tag, "_ff"},      32'(first_fail_addr), 32'(e.ff));
            check({tag, "_pass_ok"}, 32'(pass_ok), 32'(e.ok));
        end
        if (hold) begin
            @(negedge clk);
            check({tag, "_restart_busy"}, 32'(busy), 1);
            check({tag, "_restart_done"}, 32'(done), 0);
            check({tag, "_restart_ok"},   32'(pass_ok), 0);
            check({tag, "_restart_err"},  32'(error_count), 0);
            check({tag, "_restart_ff"},   32'(first_fail_addr), 0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stuck0 = 1'b0;
        fault9 = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_zero("idle_hold");

        sb_q.push_back('{err: 6'd0, ff: 4'd0, ok: 1'b1});
        run_test("good", 1'b0, 1'b0, 1'b0);
        check("good_mem5", 32'(mem[5]), 32'h5F);

        stuck0 = 1'b1;
        sb_q.push_back('{err: 6'd16, ff: 4'd1, ok: 1'b0});
        run_test("stuck", 1'b0, 1'b0, 1'b0);

        sb_q.push_back('{err: 6'd1, ff: 4'd9, ok: 1'b0});
        stuck0 = 1'b0;
        run_test("fault9", 1'b0, 1'b0, 1'b1);

        stuck0 = 1'b1;
        sb_q.push_back('{err: 6'd16, ff: 4'd1, ok: 1'b0});
        run_test("hold", 1'b1, 1'b0, 1'b0);
        start  = 1'b0;
        stuck0 = 1'b0;
        sb_q.push_back('{err: 6'd0, ff: 4'd0, ok: 1'b1});
        run_test("after_hold", 1'b0, 1'b1, 1'b0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_in_read_busy", 32'(busy), 1);
        check("abort_in_read_we",   32'(ram_write_en), 0);
        reset = 1'b1;
        #1;
        check_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sb_q.push_back('{err: 6'd0, ff: 4'd0, ok: 1'b1});
        run_test("post_abort", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
